pe_result_collector: RTL
========================

Name: pe_result_collector

Overview:
- Receives the result stream from the Winograd PE core and is the only consumer of that stream. Inputs are out_valid, result_unpool and result_pool; the core cannot be stalled.
- Requantizes each OUT_BIT accumulator to DATA_BIT with shift, round, optional ReLU and saturation.
- Buffers results in a small FIFO and emits them channel-interleaved as OUT_W-bit beats on a valid/ready bus to the output writer.
- Drives almost_full back to the layer scheduler so the scheduler can withhold in_valid.

Parameters:
X_PE, 16, output channels per result
RESULT_SIZE, 2, Winograd output tile edge (RESULT_SIZE^2 pixels per channel)
OUT_BIT, 24, accumulator width per value (signed)
DATA_BIT, 8, quantized width (signed)
DEPTH, 4, FIFO entries (power of 2, >=4)
OUT_W, X_PE*DATA_BIT = 128, output beat width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  PE core out_valid
poolop  in  1  1 = entry is pooled (result_pool), 0 = unpooled
result_unpool  in  OUT_BIT*RESULT_SIZE^2*X_PE  channel c pixel k at (c*RESULT_SIZE^2+k)*OUT_BIT
result_pool  in  OUT_BIT*X_PE  channel c at c*OUT_BIT
shamt  in  5  right-shift amount, quasi-static
relu_en  in  1  clamp negatives to 0, quasi-static
clr_ovf  in  1  clears overflow
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  beat payload
out_last  out  1  last beat of an entry
almost_full  out  1  scheduler must stop issuing in_valid
overflow  out  1  sticky: an entry was dropped

Behaviour:
- Reset (rst high at posedge): all of the following cleared:
  - FIFO pointers, count and beat counter;
  - pipeline valids;
  - out_valid=0, out_last=0, out_data=0, almost_full=0, overflow=0.
  Reset mid-burst discards in-flight data and any partially sent entry. No beat is presented in the cycle after reset.
- Stage S1 (cycle after in_valid): register the selected payload, poolop, shamt and relu_en.
- Stage S2: quantize all RESULT_SIZE^2*X_PE lanes in parallel and write one FIFO entry {mode, RESULT_SIZE^2*OUT_W bits}. Write occurs 2 cycles after in_valid.
- Quantize each signed OUT_BIT value v, computing in OUT_BIT+1 bits:
  - shamt=0: r=v.
  - Otherwise r=(v+2^(shamt-1))>>>shamt (arithmetic shift, round half up).
  - If relu_en and r<0: r=0.
  - Saturate r to [-2^(DATA_BIT-1), 2^(DATA_BIT-1)-1].
- Pooled entries use only lane k=0, from result_pool.
- Output beat mapping:
  - Unpooled entry: RESULT_SIZE^2 beats, b=0..3. out_data[c*DATA_BIT+:DATA_BIT]=q(pixel b of channel c).
  - Pooled entry: 1 beat, out_data[c*DATA_BIT+:DATA_BIT]=q(result_pool channel c).
  - out_last=1 on the final beat of each entry.
- Handshake:
  - out_valid=1 whenever the FIFO is non-empty. It is combinational from the FIFO head, with no bubble between entries.
  - A beat transfers when out_valid&&out_ready. out_data and out_last hold stable while out_valid&&!out_ready.
  - The beat counter increments per transfer. On the last-beat transfer the entry is popped and the counter returns to 0.
- FIFO write decision at S2, with F = full (count==DEPTH):
  - Write if !F.
  - Also write if F and the last-beat pop happens in the same cycle.
  - Otherwise drop the entry, set overflow=1 the next cycle, and leave the FIFO unchanged.
- overflow clears on clr_ovf. A simultaneous new drop and clr_ovf leaves overflow=1.
- Simultaneous write and pop when not full: count unchanged. Pointers wrap modulo DEPTH.
- almost_full = count + (S1 valid) + (S2 valid) >= DEPTH-1, registered. This accounts for the 2 in-flight stages so that a scheduler stopping on almost_full never overflows.
- Mode of each entry comes from the poolop value sampled with its in_valid. Mixing pooled and unpooled entries in the FIFO is legal.

Test Plan:
- Unpool, shamt=4, relu_en=0, out_ready=1: channel 0 pixels {0x000100, 0x000018, 0xFFFFF8, 0x7FFFFF} -> four beats, byte0 = 0x10, 0x02, 0x00, 0x7F. out_last only on beat 3. First out_valid 2 cycles after in_valid.
- Pool, shamt=0, relu_en=1: result_pool channel 5 = -3, channel 6 = 200 -> single beat with out_last=1, byte5 = 0x00, byte6 = 0x7F. Signed -200 with relu_en=0 -> 0x80.
- out_ready=0 with 5 unpooled in_valid pulses, DEPTH=4:
  - almost_full asserts once count+inflight >= 3.
  - 5th entry dropped, overflow=1.
  - Then out_ready=1 -> exactly 16 beats, in order.
  - clr_ovf -> overflow=0.
- FIFO full, and the 4th beat of the head transfers in the same cycle the S2 write arrives -> write accepted, count stays 4, overflow stays 0.
- Random out_ready backpressure (50%), interleaved pooled and unpooled entries: beat count per entry is 4 or 1 matching poolop, and data matches the reference model.
- Assert rst during beat 2 of an entry with 2 more entries in flight -> next cycle out_valid=0, almost_full=0, overflow=0. New in_valid after reset yields a fresh entry starting at beat 0.

Source files
------------

// File: rtl/pe_result_collector_if.sv
// pe_result_collector_if
//   Output beat bus from the PE result collector to the output writer.
//   Ports (signals):
//     out_valid  beat valid (collector -> writer)
//     out_ready  beat accept (writer -> collector)
//     out_data   OUT_W-bit beat payload
//     out_last   last beat of an entry
//   Modports: master = collector side, slave = writer side.
interface pe_result_collector_if #(
    parameter int OUT_W = 128
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/pe_result_collector.sv
// pe_result_collector
//   Sole consumer of the Winograd PE core result stream. Each result is
//   requantized (shift, round half up, optional ReLU, saturate) into one FIFO
//   entry and then streamed out channel-interleaved, one pixel per beat.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     in_valid_i          PE core out_valid (cannot be stalled)
//     poolop_i            1 = pooled entry (result_pool_i), 0 = unpooled
//     result_unpool_i     channel c pixel k at (c*RS^2+k)*OUT_BIT
//     result_pool_i       channel c at c*OUT_BIT
//     shamt_i, relu_en_i  requantization controls, captured per entry
//     clr_ovf_i           clears the sticky overflow flag
//     out_bus             beat bus (master side)
//     almost_full_o       registered back-pressure hint to the scheduler
//     overflow_o          sticky: an entry was dropped
module pe_result_collector #(
    parameter int X_PE        = 16,
    parameter int RESULT_SIZE = 2,
    parameter int OUT_BIT     = 24,
    parameter int DATA_BIT    = 8,
    parameter int DEPTH       = 4,
    parameter int OUT_W       = X_PE * DATA_BIT
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         in_valid_i,
    input  logic                                         poolop_i,
    input  logic [OUT_BIT*RESULT_SIZE*RESULT_SIZE*X_PE-1:0] result_unpool_i,
    input  logic [OUT_BIT*X_PE-1:0]                      result_pool_i,
    input  logic [4:0]                                   shamt_i,
    input  logic                                         relu_en_i,
    input  logic                                         clr_ovf_i,
    pe_result_collector_if.master                        out_bus,
    output logic                                         almost_full_o,
    output logic                                         overflow_o
);
    localparam int NPIX  = RESULT_SIZE * RESULT_SIZE;
    localparam int NLANE = NPIX * X_PE;
    localparam int ENT_W = NPIX * OUT_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int BW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int QW    = OUT_BIT + 1;
    localparam logic signed [QW-1:0] Q_MAX = QW'(2**(DATA_BIT-1) - 1);
    localparam logic signed [QW-1:0] Q_MIN = QW'(-(2**(DATA_BIT-1)));

    // S1 pipeline stage
    logic                     s1_valid_q;
    logic                     s1_pool_q;
    logic [OUT_BIT*NLANE-1:0] s1_data_q;
    logic [OUT_BIT*NLANE-1:0] s1_data_d;
    logic [4:0]               s1_shamt_q;
    logic                     s1_relu_q;

    // FIFO
    logic [ENT_W-1:0] mem_data_q [DEPTH];
    logic             mem_pool_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;

    logic [ENT_W-1:0] ent_d;
    logic             fifo_ne, full, last_beat, xfer, pop, wr_en, drop;
    logic [PW+1:0]    occupancy;

    function automatic logic [DATA_BIT-1:0] quant(input logic [OUT_BIT-1:0] v,
                                                   input logic [4:0] sh,
                                                   input logic relu);
        logic signed [QW-1:0] ext, rnd, r;
        ext = $signed({v[OUT_BIT-1], v});
        if (sh == 5'd0) begin
            r = ext;
        end else begin
            rnd = QW'(1);
            rnd = rnd <<< (sh - 5'd1);
            r   = (ext + rnd) >>> sh;
        end
        if (relu && r < 0) r = '0;
        if (r > Q_MAX)      return Q_MAX[DATA_BIT-1:0];
        else if (r < Q_MIN) return Q_MIN[DATA_BIT-1:0];
        else                return r[DATA_BIT-1:0];
    endfunction

    // Pooled values go to pixel-0 lanes so both modes share one quantizer array.
    always_comb begin
        s1_data_d = '0;
        if (poolop_i) begin
            for (int c = 0; c < X_PE; c++)
                s1_data_d[(c*NPIX)*OUT_BIT +: OUT_BIT] = result_pool_i[c*OUT_BIT +: OUT_BIT];
        end else begin
            s1_data_d = result_unpool_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i) begin
            s1_data_q  <= s1_data_d;
            s1_pool_q  <= poolop_i;
            s1_shamt_q <= shamt_i;
            s1_relu_q  <= relu_en_i;
        end
    end

    // Entry layout: beat b occupies [b*OUT_W +: OUT_W], channel c byte within it.
    always_comb begin
        ent_d = '0;
        for (int b = 0; b < NPIX; b++)
            for (int c = 0; c < X_PE; c++)
                ent_d[b*OUT_W + c*DATA_BIT +: DATA_BIT] =
                    quant(s1_data_q[(c*NPIX+b)*OUT_BIT +: OUT_BIT], s1_shamt_q, s1_relu_q);
    end

    assign fifo_ne   = (count_q != '0);
    assign full      = (count_q == (PW+1)'(DEPTH));
    assign last_beat = mem_pool_q[rd_ptr_q] || (beat_q == BW'(NPIX-1));
    assign xfer      = fifo_ne && out_bus.out_ready;
    assign pop       = xfer && last_beat;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign wr_en     = s1_valid_q && (!full || pop);
    assign drop      = s1_valid_q && full && !pop;

    assign out_bus.out_valid = fifo_ne;
    assign out_bus.out_last  = fifo_ne && last_beat;
    assign out_bus.out_data  = fifo_ne ? mem_data_q[rd_ptr_q][beat_q*OUT_W +: OUT_W] : '0;
    assign almost_full_o     = almost_full_q;
    assign overflow_o        = overflow_q;

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        beat_d = beat_q;
        if (pop)       beat_d = '0;
        else if (xfer) beat_d = beat_q + 1'b1;
        // Counts the entry entering S1 and the one being written so that a
        // scheduler reacting one cycle late still cannot overrun the FIFO.
        occupancy     = (PW+2)'(count_q) + (PW+2)'(in_valid_i) + (PW+2)'(s1_valid_q);
        almost_full_d = (occupancy >= (PW+2)'(DEPTH-1));
        overflow_d    = drop || (overflow_q && !clr_ovf_i);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_data_q[wr_ptr_q] <= ent_d;
            mem_pool_q[wr_ptr_q] <= s1_pool_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            beat_q        <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            s1_valid_q    <= in_valid_i;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q       <= count_d;
            beat_q        <= beat_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end
endmodule
